// File: rtl/proc_sim_ctrl.sv
// proc_sim_ctrl: core reset sequencer and run monitor for the multicycle core.
// Ends a run on a tohost store, watchdog expiry or PC hang; keeps statistics.
module proc_sim_ctrl #(
   parameter int              XLEN        = 32,
   parameter int              CNT_W       = 32,
   parameter int              RST_CYCLES  = 2,
   parameter int              TIMEOUT     = 1000,
   parameter int              HALT_WIN    = 16,
   parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  PC,
   input  logic [XLEN-1:0]  dAddress,
   input  logic [XLEN-1:0]  dWriteData,
   input  logic             MemRead,
   input  logic             MemWrite,
   output logic             core_rst,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             hang,
   output logic [XLEN-1:0]  exit_code,
   output logic             proto_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt
);

   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int SW = $clog2(HALT_WIN + 1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic [2:0] {
      S_RST, S_RUN, S_PASS, S_FAIL, S_TMO, S_HANG
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [RW-1:0]    r_rst_cnt;
   logic             r_first;
   logic [XLEN-1:0]  r_prev_pc;
   logic [SW-1:0]    r_stall;
   logic [XLEN-1:0]  r_exit;
   logic             r_perr;
   logic [CNT_W-1:0] r_cyc, r_ins, r_ld, r_st;
   logic             w_run, w_tohost, w_tmo, w_same, w_hang;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v, input logic en);
      return (en && v != CMAX) ? v + CNT_W'(1) : v;
   endfunction

   always_comb begin
      w_next   = r_state;
      w_run    = (r_state == S_RUN);
      w_tohost = MemWrite && (dAddress == TOHOST_ADDR);
      w_tmo    = (r_cyc == CNT_W'(TIMEOUT - 1));
      w_same   = (PC == r_prev_pc);
      w_hang   = !r_first && w_same && !MemWrite &&
                 (r_stall == SW'(HALT_WIN - 1));
      unique case (r_state)
         S_RST: if (r_rst_cnt == RW'(RST_CYCLES - 1)) w_next = S_RUN;
         S_RUN: begin
            if (w_tohost)
               w_next = (dWriteData == XLEN'(1)) ? S_PASS : S_FAIL;
            else if (w_tmo)
               w_next = S_TMO;
            else if (w_hang)
               w_next = S_HANG;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_RST;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rst_cnt <= '0;
         r_first   <= 1'b1;
         r_prev_pc <= '0;
         r_stall   <= '0;
         r_exit    <= '0;
         r_perr    <= 1'b0;
         r_cyc     <= '0;
         r_ins     <= '0;
         r_ld      <= '0;
         r_st      <= '0;
      end else begin
         if (r_state == S_RST) r_rst_cnt <= r_rst_cnt + RW'(1);
         if (w_run) begin
            r_first   <= 1'b0;
            r_prev_pc <= PC;
            // first RUN cycle only seeds prev_pc; it is not a stall
            r_stall   <= (r_first || !w_same || MemWrite) ?
                         '0 : r_stall + SW'(1);
            r_cyc     <= sat_inc(r_cyc, 1'b1);
            r_ins     <= sat_inc(r_ins, !r_first && !w_same);
            r_ld      <= sat_inc(r_ld, MemRead);
            r_st      <= sat_inc(r_st, MemWrite);
            if (MemRead && MemWrite) r_perr <= 1'b1;
            if (w_tohost) r_exit <= dWriteData >> 1;
         end
      end
   end

   assign core_rst  = (r_state == S_RST);
   assign pass      = (r_state == S_PASS);
   assign fail      = (r_state == S_FAIL);
   assign timeout   = (r_state == S_TMO);
   assign hang      = (r_state == S_HANG);
   assign done      = pass || fail || timeout || hang;
   assign exit_code = r_exit;
   assign proto_err = r_perr;
   assign cycle_cnt = r_cyc;
   assign instr_cnt = r_ins;
   assign load_cnt  = r_ld;
   assign store_cnt = r_st;

endmodule
